// File: rtl/issue_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : issue_scoreboard_pkg
//  Description : Shared types and sizing for the decode-stage hazard
//                scoreboard. Holds the operand struct types, the register,
//                predicate and FU file sizes, and the stall_cause bit layout.
//  Revision    : 1.0 - initial multi-writeback release
// ============================================================================
package issue_scoreboard_pkg;

    localparam int REG_ADDR_SIZE     = 4;
    localparam int PRED_ADDR_SIZE    = 2;
    localparam int FUNC_UNIT_OP_SIZE = 3;
    localparam int NUM_WB_PORTS      = 2;

    localparam int REG_FILE_SIZE  = 1 << REG_ADDR_SIZE;
    localparam int PRED_FILE_SIZE = 1 << PRED_ADDR_SIZE;
    localparam int NUM_FUNC_UNITS = 1 << FUNC_UNIT_OP_SIZE;

    // stall_cause bit positions
    localparam int c_CAUSE_SRC_RAW  = 0;
    localparam int c_CAUSE_DEST_WAW = 1;
    localparam int c_CAUSE_PEND_OVF = 2;
    localparam int c_CAUSE_FU       = 3;

    typedef struct packed {
        logic [REG_ADDR_SIZE-1:0] addr;
        logic                     valid;
    } reg_operand_t;

    typedef struct packed {
        logic [PRED_ADDR_SIZE-1:0] addr;
        logic                      valid;
    } pred_operand_t;

endpackage
`default_nettype wire

// File: rtl/issue_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : issue_scoreboard_if
//  Description : Decode/execute <-> scoreboard bundle.
//                master : decode + execute side (drives the instruction,
//                         writeback strobes and FU-done returns)
//                slave  : the scoreboard (drives ready, stall and error status)
//  Revision    : 1.0 - initial multi-writeback release
// ============================================================================
interface issue_scoreboard_if;
    import issue_scoreboard_pkg::*;

    logic                                   issue_valid;
    logic                                   issue_ready;
    logic                                   pred_ins;
    logic [PRED_ADDR_SIZE-1:0]              pred_addr;
    reg_operand_t                           reg_dest;
    reg_operand_t                           reg_src1;
    reg_operand_t                           reg_src2;
    pred_operand_t                          pred_dest;
    pred_operand_t                          pred_src1;
    pred_operand_t                          pred_src2;
    logic [FUNC_UNIT_OP_SIZE-1:0]           func_unit;
    logic [NUM_WB_PORTS-1:0]                wr_reg;
    logic [NUM_WB_PORTS*REG_ADDR_SIZE-1:0]  wr_reg_addr;
    logic [NUM_WB_PORTS-1:0]                wr_pred;
    logic [NUM_WB_PORTS*PRED_ADDR_SIZE-1:0] wr_pred_addr;
    logic [NUM_FUNC_UNITS-1:0]              fu_done;
    logic                                   predicate_valid;
    logic                                   resource_stall;
    logic [3:0]                             stall_cause;
    logic                                   sb_error;

    modport master (
        output issue_valid, pred_ins, pred_addr,
        output reg_dest, reg_src1, reg_src2,
        output pred_dest, pred_src1, pred_src2, func_unit,
        output wr_reg, wr_reg_addr, wr_pred, wr_pred_addr, fu_done,
        input  issue_ready, predicate_valid, resource_stall, stall_cause, sb_error
    );

    modport slave (
        input  issue_valid, pred_ins, pred_addr,
        input  reg_dest, reg_src1, reg_src2,
        input  pred_dest, pred_src1, pred_src2, func_unit,
        input  wr_reg, wr_reg_addr, wr_pred, wr_pred_addr, fu_done,
        output issue_ready, predicate_valid, resource_stall, stall_cause, sb_error
    );

endinterface
`default_nettype wire

// File: rtl/issue_scoreboard_pend_counter_file.sv
`default_nettype none
// ============================================================================
//  Module      : pend_counter_file
//  Description : One saturating-at-zero pending-write counter per register.
//                Ports: clk, reset (async, active-low), i_inc/i_inc_addr
//                (one issue increment), i_wb/i_wb_addr (packed writeback
//                ports, port 0 in LSBs), o_pending (count != 0),
//                o_clear_now (this cycle's writebacks drain the count),
//                o_full (count at maximum), o_err (underflow pulse).
//  Revision    : 1.0 - initial multi-writeback release
// ============================================================================
module pend_counter_file #(
    parameter int ADDR_SIZE    = 4,
    parameter int CNT_WIDTH    = 2,
    parameter int NUM_WB_PORTS = 2
) (
    input  wire logic                              clk,
    input  wire logic                              reset,
    input  wire logic                              i_inc,
    input  wire logic [ADDR_SIZE-1:0]              i_inc_addr,
    input  wire logic [NUM_WB_PORTS-1:0]           i_wb,
    input  wire logic [NUM_WB_PORTS*ADDR_SIZE-1:0] i_wb_addr,
    output wire logic [(1<<ADDR_SIZE)-1:0]         o_pending,
    output wire logic [(1<<ADDR_SIZE)-1:0]         o_clear_now,
    output wire logic [(1<<ADDR_SIZE)-1:0]         o_full,
    output wire logic                              o_err
);
    localparam int c_SIZE  = 1 << ADDR_SIZE;
    localparam int c_DEC_W = $clog2(NUM_WB_PORTS + 1);
    localparam int c_SUM_W = ((CNT_WIDTH > c_DEC_W) ? CNT_WIDTH : c_DEC_W) + 1;

    wire [c_SIZE-1:0] w_underflow;

    for (genvar e = 0; e < c_SIZE; e++) begin : g_entry
        logic [CNT_WIDTH-1:0] r_cnt;
        logic [c_DEC_W-1:0]   w_dec;
        logic [c_SUM_W-1:0]   w_sum;
        logic [c_SUM_W-1:0]   w_dec_ext;
        logic                 w_inc;

        // Several writeback ports may retire writes to the same register.
        always_comb begin
            w_dec = '0;
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                if (i_wb[p] && (i_wb_addr[p*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(e))) begin
                    w_dec = w_dec + c_DEC_W'(1);
                end
            end
        end

        assign w_inc       = i_inc && (i_inc_addr == ADDR_SIZE'(e));
        assign w_sum       = c_SUM_W'(r_cnt) + c_SUM_W'(w_inc);
        assign w_dec_ext   = c_SUM_W'(w_dec);
        assign w_underflow[e] = w_dec_ext > w_sum;

        assign o_pending[e]   = (r_cnt != '0);
        // The issuing instruction's own increment is excluded: it reads its
        // sources before its destination write exists, and excluding it keeps
        // the ready path free of a combinational loop through fire.
        assign o_clear_now[e] = (w_dec_ext >= c_SUM_W'(r_cnt));
        assign o_full[e]      = (r_cnt == {CNT_WIDTH{1'b1}});

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt <= '0;
            end else if (w_underflow[e]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= CNT_WIDTH'(w_sum - w_dec_ext);
            end
        end
    end

    assign o_err = |w_underflow;

endmodule
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : issue_scoreboard
//  Description : Decode-stage hazard scoreboard. Tracks pending GPR and
//                predicate writes and per-FU credits, and gates issue through
//                a valid/ready handshake with a zero-cycle decision.
//                Ports: clk, reset (async, active-low), sb (slave modport
//                carrying instruction, writeback, FU-done and status signals).
//  Revision    : 1.0 - initial multi-writeback release
// ============================================================================
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int PEND_CNT_WIDTH = 2,
    parameter int FU_CREDITS     = 1,
    parameter int CREDIT_WIDTH   = 2,
    parameter int WB_BYPASS      = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    issue_scoreboard_if.slave sb
);
    localparam int c_CW1 = CREDIT_WIDTH + 1;
    localparam logic [CREDIT_WIDTH:0] c_CREDIT_MAX = c_CW1'(FU_CREDITS);

    wire  [REG_FILE_SIZE-1:0]  w_reg_pending, w_reg_clear, w_reg_full;
    wire  [PRED_FILE_SIZE-1:0] w_pred_pending, w_pred_clear, w_pred_full;
    logic [REG_FILE_SIZE-1:0]  w_reg_busy;
    logic [PRED_FILE_SIZE-1:0] w_pred_busy;
    wire  [NUM_FUNC_UNITS-1:0] w_fu_empty, w_fu_err;
    wire                       w_reg_err, w_pred_err;
    logic                      w_src_raw, w_dest_waw, w_pend_ovf, w_fu_stall;
    logic                      w_ready, w_fire;
    logic                      r_sb_error;

    pend_counter_file #(
        .ADDR_SIZE    (REG_ADDR_SIZE),
        .CNT_WIDTH    (PEND_CNT_WIDTH),
        .NUM_WB_PORTS (NUM_WB_PORTS)
    ) u_reg_pend (
        .clk         (clk),
        .reset       (reset),
        .i_inc       (w_fire && sb.reg_dest.valid),
        .i_inc_addr  (sb.reg_dest.addr),
        .i_wb        (sb.wr_reg),
        .i_wb_addr   (sb.wr_reg_addr),
        .o_pending   (w_reg_pending),
        .o_clear_now (w_reg_clear),
        .o_full      (w_reg_full),
        .o_err       (w_reg_err)
    );

    pend_counter_file #(
        .ADDR_SIZE    (PRED_ADDR_SIZE),
        .CNT_WIDTH    (PEND_CNT_WIDTH),
        .NUM_WB_PORTS (NUM_WB_PORTS)
    ) u_pred_pend (
        .clk         (clk),
        .reset       (reset),
        .i_inc       (w_fire && sb.pred_dest.valid),
        .i_inc_addr  (sb.pred_dest.addr),
        .i_wb        (sb.wr_pred),
        .i_wb_addr   (sb.wr_pred_addr),
        .o_pending   (w_pred_pending),
        .o_clear_now (w_pred_clear),
        .o_full      (w_pred_full),
        .o_err       (w_pred_err)
    );

    // Source-side view: a same-cycle writeback that drains the counter
    // releases the hazard when bypass is enabled.
    assign w_reg_busy  = (WB_BYPASS != 0) ? (w_reg_pending  & ~w_reg_clear)  : w_reg_pending;
    assign w_pred_busy = (WB_BYPASS != 0) ? (w_pred_pending & ~w_pred_clear) : w_pred_pending;

    assign w_src_raw  = (sb.reg_src1.valid  && w_reg_busy[sb.reg_src1.addr])
                     || (sb.reg_src2.valid  && w_reg_busy[sb.reg_src2.addr])
                     || (sb.pred_src1.valid && w_pred_busy[sb.pred_src1.addr])
                     || (sb.pred_src2.valid && w_pred_busy[sb.pred_src2.addr])
                     || (sb.pred_ins        && w_pred_busy[sb.pred_addr]);
    // Multiple outstanding writes are legal, so WAW is reported but never stalls.
    assign w_dest_waw = (sb.reg_dest.valid  && w_reg_pending[sb.reg_dest.addr])
                     || (sb.pred_dest.valid && w_pred_pending[sb.pred_dest.addr]);
    assign w_pend_ovf = (sb.reg_dest.valid  && w_reg_full[sb.reg_dest.addr])
                     || (sb.pred_dest.valid && w_pred_full[sb.pred_dest.addr]);
    // Credit check uses the registered count only; fu_done is not bypassed.
    assign w_fu_stall = w_fu_empty[sb.func_unit];

    assign w_ready = !(w_src_raw || w_pend_ovf || w_fu_stall);
    assign w_fire  = sb.issue_valid && w_ready;

    assign sb.issue_ready     = w_ready;
    assign sb.resource_stall  = sb.issue_valid && !w_ready;
    assign sb.predicate_valid = !w_pred_busy[sb.pred_addr];
    assign sb.sb_error        = r_sb_error;

    always_comb begin
        sb.stall_cause = '0;
        if (sb.issue_valid) begin
            sb.stall_cause[c_CAUSE_SRC_RAW]  = w_src_raw;
            sb.stall_cause[c_CAUSE_DEST_WAW] = w_dest_waw;
            sb.stall_cause[c_CAUSE_PEND_OVF] = w_pend_ovf;
            sb.stall_cause[c_CAUSE_FU]       = w_fu_stall;
        end
    end

    for (genvar u = 0; u < NUM_FUNC_UNITS; u++) begin : g_fu
        logic [CREDIT_WIDTH-1:0] r_credit;
        logic [CREDIT_WIDTH:0]   w_next;
        logic                    w_take;

        assign w_take = w_fire && (sb.func_unit == FUNC_UNIT_OP_SIZE'(u));
        // Never negative: a take requires a non-zero credit.
        assign w_next = {1'b0, r_credit} + c_CW1'(sb.fu_done[u]) - c_CW1'(w_take);
        assign w_fu_err[u]   = (w_next > c_CREDIT_MAX);
        assign w_fu_empty[u] = (r_credit == '0);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_credit <= CREDIT_WIDTH'(FU_CREDITS);
            end else if (!w_fu_err[u]) begin
                r_credit <= w_next[CREDIT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sb_error <= 1'b0;
        end else if (w_reg_err || w_pred_err || (|w_fu_err)) begin
            r_sb_error <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_scoreboard
//  Description : Self-checking bench for issue_scoreboard. Directed scenarios
//                followed by randomized traffic, compared every cycle against
//                a count-based reference model of the hazard rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    localparam int c_CNT_MAX    = 3;
    localparam int c_FU_CREDITS = 1;
    localparam bit c_BYPASS     = 1'b1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: plain counts per register / predicate / FU.
    int m_reg  [REG_FILE_SIZE];
    int m_pred [PRED_FILE_SIZE];
    int m_cred [NUM_FUNC_UNITS];
    bit m_err;
    int dr [REG_FILE_SIZE];
    int dp [PRED_FILE_SIZE];
    bit e_fire;

    issue_scoreboard_if sb_if ();

    issue_scoreboard #(
        .PEND_CNT_WIDTH (2),
        .FU_CREDITS     (c_FU_CREDITS),
        .CREDIT_WIDTH   (2),
        .WB_BYPASS      (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_reg[a])  m_reg[a]  = 0;
        foreach (m_pred[a]) m_pred[a] = 0;
        foreach (m_cred[u]) m_cred[u] = c_FU_CREDITS;
        m_err = 1'b0;
    endtask

    task automatic set_idle();
        sb_if.issue_valid  = 1'b0;
        sb_if.pred_ins     = 1'b0;
        sb_if.pred_addr    = '0;
        sb_if.reg_dest     = '0;
        sb_if.reg_src1     = '0;
        sb_if.reg_src2     = '0;
        sb_if.pred_dest    = '0;
        sb_if.pred_src1    = '0;
        sb_if.pred_src2    = '0;
        sb_if.func_unit    = '0;
        sb_if.wr_reg       = '0;
        sb_if.wr_reg_addr  = '0;
        sb_if.wr_pred      = '0;
        sb_if.wr_pred_addr = '0;
        sb_if.fu_done      = '0;
    endtask

    // Compute expected outputs from the model and current inputs, then compare.
    task automatic eval();
        bit rb [REG_FILE_SIZE];
        bit pb [PRED_FILE_SIZE];
        bit raw, waw, ovf, fub, rdy;
        #1;
        foreach (dr[a]) dr[a] = 0;
        foreach (dp[a]) dp[a] = 0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (sb_if.wr_reg[p])  dr[sb_if.wr_reg_addr[p*REG_ADDR_SIZE +: REG_ADDR_SIZE]]++;
            if (sb_if.wr_pred[p]) dp[sb_if.wr_pred_addr[p*PRED_ADDR_SIZE +: PRED_ADDR_SIZE]]++;
        end
        foreach (rb[a]) rb[a] = (m_reg[a] > 0)  && !(c_BYPASS && dr[a] >= m_reg[a]);
        foreach (pb[a]) pb[a] = (m_pred[a] > 0) && !(c_BYPASS && dp[a] >= m_pred[a]);
        raw = (sb_if.reg_src1.valid  && rb[sb_if.reg_src1.addr])  ||
              (sb_if.reg_src2.valid  && rb[sb_if.reg_src2.addr])  ||
              (sb_if.pred_src1.valid && pb[sb_if.pred_src1.addr]) ||
              (sb_if.pred_src2.valid && pb[sb_if.pred_src2.addr]) ||
              (sb_if.pred_ins        && pb[sb_if.pred_addr]);
        waw = (sb_if.reg_dest.valid  && m_reg[sb_if.reg_dest.addr] > 0) ||
              (sb_if.pred_dest.valid && m_pred[sb_if.pred_dest.addr] > 0);
        ovf = (sb_if.reg_dest.valid  && m_reg[sb_if.reg_dest.addr] == c_CNT_MAX) ||
              (sb_if.pred_dest.valid && m_pred[sb_if.pred_dest.addr] == c_CNT_MAX);
        fub = (m_cred[sb_if.func_unit] == 0);
        rdy = !(raw || ovf || fub);
        e_fire = sb_if.issue_valid && rdy;
        check("issue_ready",     32'(sb_if.issue_ready),     32'(rdy));
        check("stall_cause",     32'(sb_if.stall_cause),     sb_if.issue_valid ? 32'({fub, ovf, waw, raw}) : 32'd0);
        check("resource_stall",  32'(sb_if.resource_stall),  32'(sb_if.issue_valid && !rdy));
        check("predicate_valid", 32'(sb_if.predicate_valid), 32'(!pb[sb_if.pred_addr]));
        check("sb_error",        32'(sb_if.sb_error),        32'(m_err));
    endtask

    // Clock edge: update the model from the inputs that were just evaluated.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            foreach (m_reg[a]) begin
                int n = m_reg[a] - dr[a];
                if (e_fire && sb_if.reg_dest.valid && sb_if.reg_dest.addr == a) n++;
                if (n < 0) begin n = 0; m_err = 1'b1; end
                m_reg[a] = n;
            end
            foreach (m_pred[a]) begin
                int n = m_pred[a] - dp[a];
                if (e_fire && sb_if.pred_dest.valid && sb_if.pred_dest.addr == a) n++;
                if (n < 0) begin n = 0; m_err = 1'b1; end
                m_pred[a] = n;
            end
            foreach (m_cred[u]) begin
                int n = m_cred[u] + int'(sb_if.fu_done[u]);
                if (e_fire && sb_if.func_unit == u) n--;
                if (n > c_FU_CREDITS) m_err = 1'b1;
                else                  m_cred[u] = n;
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        eval();
        advance();
    endtask

    // Assert reset for one cycle with whatever inputs are present.
    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        eval();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic rand_inputs(input int err_pct);
        int tr [REG_FILE_SIZE];
        int tp [PRED_FILE_SIZE];
        int q [$];
        sb_if.issue_valid     = ($urandom_range(0, 3) != 0);
        sb_if.reg_dest.valid  = ($urandom_range(0, 9) < 7);
        sb_if.reg_dest.addr   = REG_ADDR_SIZE'($urandom_range(0, 5));
        sb_if.reg_src1.valid  = $urandom_range(0, 1) != 0;
        sb_if.reg_src1.addr   = REG_ADDR_SIZE'($urandom_range(0, 5));
        sb_if.reg_src2.valid  = $urandom_range(0, 1) != 0;
        sb_if.reg_src2.addr   = REG_ADDR_SIZE'($urandom_range(0, 5));
        sb_if.pred_dest.valid = ($urandom_range(0, 9) < 3);
        sb_if.pred_dest.addr  = PRED_ADDR_SIZE'($urandom_range(0, 3));
        sb_if.pred_src1.valid = ($urandom_range(0, 9) < 3);
        sb_if.pred_src1.addr  = PRED_ADDR_SIZE'($urandom_range(0, 3));
        sb_if.pred_src2.valid = ($urandom_range(0, 9) < 3);
        sb_if.pred_src2.addr  = PRED_ADDR_SIZE'($urandom_range(0, 3));
        sb_if.pred_ins        = ($urandom_range(0, 9) < 3);
        sb_if.pred_addr       = PRED_ADDR_SIZE'($urandom_range(0, 3));
        sb_if.func_unit       = FUNC_UNIT_OP_SIZE'($urandom_range(0, 3));
        tr = m_reg;
        tp = m_pred;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
            sb_if.wr_reg[p] = 1'b0;
            sb_if.wr_reg_addr[p*REG_ADDR_SIZE +: REG_ADDR_SIZE] = '0;
            if ($urandom_range(0, 99) < err_pct) begin
                sb_if.wr_reg[p] = 1'b1;
                sb_if.wr_reg_addr[p*REG_ADDR_SIZE +: REG_ADDR_SIZE] = REG_ADDR_SIZE'($urandom_range(0, 15));
            end else if ($urandom_range(0, 1) != 0) begin
                q.delete();
                foreach (tr[a]) if (tr[a] > 0) q.push_back(a);
                if (q.size() > 0) begin
                    int a = q[$urandom_range(0, q.size() - 1)];
                    tr[a]--;
                    sb_if.wr_reg[p] = 1'b1;
                    sb_if.wr_reg_addr[p*REG_ADDR_SIZE +: REG_ADDR_SIZE] = REG_ADDR_SIZE'(a);
                end
            end
            sb_if.wr_pred[p] = 1'b0;
            sb_if.wr_pred_addr[p*PRED_ADDR_SIZE +: PRED_ADDR_SIZE] = '0;
            if ($urandom_range(0, 99) < err_pct) begin
                sb_if.wr_pred[p] = 1'b1;
                sb_if.wr_pred_addr[p*PRED_ADDR_SIZE +: PRED_ADDR_SIZE] = PRED_ADDR_SIZE'($urandom_range(0, 3));
            end else if ($urandom_range(0, 1) != 0) begin
                q.delete();
                foreach (tp[a]) if (tp[a] > 0) q.push_back(a);
                if (q.size() > 0) begin
                    int a = q[$urandom_range(0, q.size() - 1)];
                    tp[a]--;
                    sb_if.wr_pred[p] = 1'b1;
                    sb_if.wr_pred_addr[p*PRED_ADDR_SIZE +: PRED_ADDR_SIZE] = PRED_ADDR_SIZE'(a);
                end
            end
        end
        for (int u = 0; u < NUM_FUNC_UNITS; u++) begin
            sb_if.fu_done[u] = ($urandom_range(0, 99) < err_pct) ||
                               ((m_cred[u] < c_FU_CREDITS) && ($urandom_range(0, 1) != 0));
        end
    endtask

    initial begin
        set_idle();
        model_reset();
        @(negedge clk);
        apply_reset();

        // Reset discards an outstanding write to r3
        sb_if.issue_valid = 1'b1;
        sb_if.reg_dest    = '{addr: REG_ADDR_SIZE'(3), valid: 1'b1};
        cycle();
        set_idle();
        sb_if.reg_src1 = '{addr: REG_ADDR_SIZE'(3), valid: 1'b1};
        eval(); check("t1_r3_pending", 32'(sb_if.issue_ready), 32'd0); advance();
        apply_reset();
        eval(); check("t1_r3_cleared", 32'(sb_if.issue_ready), 32'd1); advance();

        // RAW on r5, then released by a same-cycle writeback
        apply_reset(); set_idle();
        sb_if.issue_valid = 1'b1;
        sb_if.reg_dest    = '{addr: REG_ADDR_SIZE'(5), valid: 1'b1};
        cycle();
        sb_if.reg_dest  = '0;
        sb_if.reg_src1  = '{addr: REG_ADDR_SIZE'(5), valid: 1'b1};
        sb_if.func_unit = FUNC_UNIT_OP_SIZE'(1);
        eval(); check("t2_raw_ready", 32'(sb_if.issue_ready), 32'd0);
        check("t2_raw_cause", 32'(sb_if.stall_cause), 32'h1); advance();
        sb_if.wr_reg = 2'b01;
        sb_if.wr_reg_addr = '0;
        sb_if.wr_reg_addr[REG_ADDR_SIZE-1:0] = REG_ADDR_SIZE'(5);
        eval(); check("t2_bypass_ready", 32'(sb_if.issue_ready), 32'd1); advance();

        // Pending counter saturation on r2, dual-port drain 3 -> 1
        apply_reset(); set_idle();
        sb_if.issue_valid = 1'b1;
        sb_if.reg_dest    = '{addr: REG_ADDR_SIZE'(2), valid: 1'b1};
        for (int i = 0; i < 3; i++) begin
            sb_if.func_unit = FUNC_UNIT_OP_SIZE'(i);
            cycle();
        end
        sb_if.func_unit = FUNC_UNIT_OP_SIZE'(4);
        eval(); check("t3_ovf_ready", 32'(sb_if.issue_ready), 32'd0);
        check("t3_ovf_cause", 32'(sb_if.stall_cause[c_CAUSE_PEND_OVF]), 32'd1);
        sb_if.issue_valid = 1'b0;
        sb_if.wr_reg      = 2'b11;
        sb_if.wr_reg_addr = {REG_ADDR_SIZE'(2), REG_ADDR_SIZE'(2)};
        eval(); advance();
        set_idle();
        sb_if.issue_valid = 1'b1;
        sb_if.reg_dest    = '{addr: REG_ADDR_SIZE'(2), valid: 1'b1};
        sb_if.func_unit   = FUNC_UNIT_OP_SIZE'(4);
        eval(); check("t3_after_drain", 32'(sb_if.stall_cause), 32'h2); advance();

        // FU 3 credit exhaustion and return (no same-cycle bypass)
        apply_reset(); set_idle();
        sb_if.issue_valid = 1'b1;
        sb_if.func_unit   = FUNC_UNIT_OP_SIZE'(3);
        cycle();
        eval(); check("t4_fu_cause", 32'(sb_if.stall_cause), 32'h8); advance();
        sb_if.fu_done[3] = 1'b1;
        eval(); check("t4_no_bypass", 32'(sb_if.issue_ready), 32'd0); advance();
        sb_if.fu_done[3] = 1'b0;
        eval(); check("t4_credit_back", 32'(sb_if.issue_ready), 32'd1); advance();

        // Guard predicate p1 pending, released by wr_pred
        apply_reset(); set_idle();
        sb_if.issue_valid = 1'b1;
        sb_if.pred_dest   = '{addr: PRED_ADDR_SIZE'(1), valid: 1'b1};
        cycle();
        sb_if.pred_dest = '0;
        sb_if.pred_ins  = 1'b1;
        sb_if.pred_addr = PRED_ADDR_SIZE'(1);
        sb_if.func_unit = FUNC_UNIT_OP_SIZE'(1);
        eval(); check("t5_pred_valid", 32'(sb_if.predicate_valid), 32'd0);
        check("t5_pred_ready", 32'(sb_if.issue_ready), 32'd0); advance();
        sb_if.wr_pred = 2'b01;
        sb_if.wr_pred_addr = '0;
        sb_if.wr_pred_addr[PRED_ADDR_SIZE-1:0] = PRED_ADDR_SIZE'(1);
        eval(); check("t5_pred_release", 32'(sb_if.predicate_valid), 32'd1); advance();

        // Writeback to an idle r7 is an error, sticky until reset
        apply_reset(); set_idle();
        sb_if.wr_reg = 2'b01;
        sb_if.wr_reg_addr[REG_ADDR_SIZE-1:0] = REG_ADDR_SIZE'(7);
        cycle();
        set_idle();
        eval(); check("t6_err_set", 32'(sb_if.sb_error), 32'd1); advance();
        for (int i = 0; i < 3; i++) cycle();
        eval(); check("t6_err_sticky", 32'(sb_if.sb_error), 32'd1); advance();
        apply_reset();
        eval(); check("t6_err_cleared", 32'(sb_if.sb_error), 32'd0); advance();

        // Randomized traffic: legal phase, then a phase with illegal returns
        for (int i = 0; i < 3000; i++) begin
            rand_inputs((i >= 2000) ? 3 : 0);
            if ((i % 500) == 250) apply_reset();
            else                  cycle();
        end
        set_idle();
        apply_reset();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
